// File: rtl/imem_arbiter.sv
// Instruction-RAM arbiter: single-port RAM shared between core fetches and a program loader.
// The loader locks the core out for the whole session; fetch data returns one cycle after grant.
module imem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_addr,
    output logic              fetch_gnt,
    output logic              fetch_rvalid,
    output logic [DATA_W-1:0] fetch_rdata,
    input  logic              load_en,
    input  logic              load_req,
    input  logic [31:0]       load_addr,
    input  logic [DATA_W-1:0] load_wdata,
    output logic              load_gnt,
    output logic              core_stall,
    output logic [ADDR_W:0]   load_count,
    output logic              err_misalign,
    output logic              err_range,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, FETCH, LOAD} state_t;

    localparam logic [ADDR_W:0] COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    state_t state, next_state;
    logic   fetch_grant, load_grant, range_bad, enter_load;

    assign range_bad  = |load_addr[31:ADDR_W+2];
    assign enter_load = (state != LOAD) && load_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE, FETCH: begin
                if (load_en)        next_state = LOAD;
                else if (fetch_req) next_state = FETCH;
                else                next_state = IDLE;
            end
            LOAD:    next_state = load_en ? LOAD : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Internal grants stay free of rst_n so no flop sees the reset as data;
    // the reset gating is applied only on the outputs.
    always_comb begin
        fetch_grant  = 1'b0;
        load_grant   = 1'b0;
        fetch_gnt    = 1'b0;
        fetch_rvalid = 1'b0;
        load_gnt     = 1'b0;
        mem_we       = 1'b0;
        core_stall   = 1'b0;
        mem_addr     = fetch_addr[ADDR_W+1:2];
        mem_wdata    = load_wdata;
        fetch_rdata  = mem_rdata;
        unique case (state)
            IDLE, FETCH: fetch_grant = !load_en && fetch_req;
            LOAD: begin
                load_grant = load_en && load_req;
                mem_addr   = load_addr[ADDR_W+1:2];
            end
            default: ;
        endcase
        if (rst_n) begin
            fetch_gnt    = fetch_grant;
            fetch_rvalid = (state == FETCH);
            load_gnt     = load_grant;
            mem_we       = load_grant && !range_bad;
            core_stall   = (state == LOAD) || load_en;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_count   <= '0;
            err_misalign <= 1'b0;
            err_range    <= 1'b0;
        end else begin
            if (enter_load)
                load_count <= '0;
            else if (load_grant && load_count != COUNT_MAX)
                load_count <= load_count + 1'b1;
            if ((fetch_grant && fetch_addr[1:0] != 2'b00) ||
                (load_grant && load_addr[1:0] != 2'b00))
                err_misalign <= 1'b1;
            if (load_grant && range_bad)
                err_range <= 1'b1;
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a synchronous-read RAM model preloaded word[i]=i.
module tb_imem_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              fetch_req;
    logic [31:0]       fetch_addr;
    logic              fetch_gnt, fetch_rvalid;
    logic [DATA_W-1:0] fetch_rdata;
    logic              load_en, load_req;
    logic [31:0]       load_addr;
    logic [DATA_W-1:0] load_wdata;
    logic              load_gnt, core_stall;
    logic [ADDR_W:0]   load_count;
    logic              err_misalign, err_range;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    imem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_gnt(fetch_gnt), .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
        .load_en(load_en), .load_req(load_req), .load_addr(load_addr), .load_wdata(load_wdata),
        .load_gnt(load_gnt), .core_stall(core_stall), .load_count(load_count),
        .err_misalign(err_misalign), .err_range(err_range),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = i;
        mem_rdata  = '0;
        rst_n      = 1'b0;
        fetch_req  = 1'b1;
        fetch_addr = 32'h0;
        load_en    = 1'b1;
        load_req   = 1'b1;
        load_addr  = 32'h0;
        load_wdata = '0;

        // Reset: outputs forced low even with requests asserted
        #1;
        chk("rst_fetch_gnt", fetch_gnt, 0);
        chk("rst_load_gnt", load_gnt, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_core_stall", core_stall, 0);
        chk("rst_rvalid", fetch_rvalid, 0);
        chk("rst_count", load_count, 0);
        chk("rst_errs", {err_misalign, err_range}, 0);
        fetch_req = 1'b0;
        load_en   = 1'b0;
        load_req  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // Back-to-back fetches of 0x0, 0x4, 0x8
        fetch_req = 1'b1; fetch_addr = 32'h0;
        #1;
        chk("f0_gnt", fetch_gnt, 1);
        chk("f0_rvalid", fetch_rvalid, 0);
        chk("f0_addr", mem_addr, 0);
        tick();
        fetch_addr = 32'h4; #1;
        chk("f1_rvalid", fetch_rvalid, 1);
        chk("f1_rdata", fetch_rdata, 0);
        chk("f1_gnt", fetch_gnt, 1);
        tick();
        fetch_addr = 32'h8; #1;
        chk("f2_rvalid", fetch_rvalid, 1);
        chk("f2_rdata", fetch_rdata, 1);
        chk("f2_gnt", fetch_gnt, 1);
        tick();

        // load_en arrives during FETCH with a fetch still requested
        fetch_addr = 32'hC; load_en = 1'b1; #1;
        chk("pre_rvalid", fetch_rvalid, 1);
        chk("pre_rdata", fetch_rdata, 2);
        chk("pre_fetch_gnt", fetch_gnt, 0);
        chk("pre_load_gnt", load_gnt, 0);
        chk("pre_stall", core_stall, 1);
        tick();
        chk("load_rvalid", fetch_rvalid, 0);

        // Load session: 0xDEAD0000+k to byte address 4k
        for (int k = 0; k < 4; k++) begin
            load_req = 1'b1; load_addr = 32'(4 * k); load_wdata = 32'hDEAD0000 + 32'(k);
            #1;
            chk("ld_gnt", load_gnt, 1);
            chk("ld_we", mem_we, 1);
            chk("ld_addr", mem_addr, k);
            chk("ld_no_fetch_gnt", fetch_gnt, 0);
            tick();
        end
        load_en = 1'b0; #1;
        chk("ld_end_gnt", load_gnt, 0);
        chk("ld_end_we", mem_we, 0);
        chk("ld_end_stall", core_stall, 1);
        tick();
        load_req = 1'b0; fetch_req = 1'b1; fetch_addr = 32'h8; #1;
        chk("ld_count4", load_count, 4);
        chk("idle_stall", core_stall, 0);
        chk("f8_gnt", fetch_gnt, 1);
        tick();
        fetch_req = 1'b0; #1;
        chk("f8_rvalid", fetch_rvalid, 1);
        chk("f8_rdata", fetch_rdata, 32'hDEAD0002);
        chk("no_errs", {err_misalign, err_range}, 0);
        tick();

        // Out-of-range load then misaligned fetch
        load_en = 1'b1; #1;
        chk("enter_gnt", load_gnt, 0);
        chk("enter_stall", core_stall, 1);
        tick();
        load_req = 1'b1; load_addr = 32'h1000; load_wdata = 32'h55; #1;
        chk("oor_gnt", load_gnt, 1);
        chk("oor_we", mem_we, 0);
        tick();
        load_en = 1'b0; load_req = 1'b0; #1;
        chk("oor_err_range", err_range, 1);
        chk("oor_misalign", err_misalign, 0);
        chk("oor_count", load_count, 1);
        tick();
        fetch_req = 1'b1; fetch_addr = 32'h5; #1;
        chk("mis_gnt", fetch_gnt, 1);
        chk("mis_addr", mem_addr, 1);
        tick();
        fetch_addr = 32'h0; #1;
        chk("mis_rdata", fetch_rdata, 32'hDEAD0001);
        chk("mis_err", err_misalign, 1);
        tick();
        fetch_req = 1'b0; #1;
        chk("oor_nowrite", fetch_rdata, 32'hDEAD0000);
        tick();

        // Saturation: 1025 grants in one session
        load_en = 1'b1;
        tick();
        chk("sat_cleared", load_count, 0);
        for (int i = 0; i < 1025; i++) begin
            load_req = 1'b1; load_addr = 32'(4 * (i % 1024)); load_wdata = 32'(i);
            tick();
            if (i == 1023) chk("sat_1024", load_count, 1024);
        end
        chk("sat_hold", load_count, 1024);

        // Reset mid-LOAD with load_req held
        #1;
        chk("mid_gnt", load_gnt, 1);
        chk("mid_we", mem_we, 1);
        rst_n = 1'b0; #1;
        chk("mid_rst_we", mem_we, 0);
        chk("mid_rst_gnt", load_gnt, 0);
        chk("mid_rst_stall", core_stall, 0);
        chk("mid_rst_count", load_count, 0);
        chk("mid_rst_errs", {err_misalign, err_range}, 0);
        load_en = 1'b0; load_req = 1'b0;
        tick();
        rst_n = 1'b1; #1;
        chk("post_rst_we", mem_we, 0);
        chk("post_rst_stall", core_stall, 0);
        tick();

        // Reset mid-FETCH: granted fetch produces no rvalid afterwards
        fetch_req = 1'b1; fetch_addr = 32'h10; #1;
        chk("rf_gnt", fetch_gnt, 1);
        rst_n = 1'b0; fetch_req = 1'b0; #1;
        rst_n = 1'b1;
        tick();
        chk("rf_no_rvalid", fetch_rvalid, 0);
        chk("rf_count", load_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 10, instruction RAM word-address width (2^ADDR_W words).
REQ-002 Parameter: DATA_W, 32, instruction word width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 fetch_req  in  1  core requests an instruction read.
REQ-006 fetch_addr  in  32  fetch byte address; word index is fetch_addr[ADDR_W+1:2].
REQ-007 fetch_gnt  out  1  fetch accepted this cycle.
REQ-008 fetch_rvalid  out  1  fetch_rdata valid this cycle.
REQ-009 fetch_rdata  out  DATA_W  instruction word returned to core.
REQ-010 load_en  in  1  program-loader session active; core is locked out.
REQ-011 load_req  in  1  loader write request.
REQ-012 load_addr  in  32  loader byte address.
REQ-013 load_wdata  in  DATA_W  loader write data.
REQ-014 load_gnt  out  1  loader write accepted this cycle.
REQ-015 core_stall  out  1  core must hold its PC.
REQ-016 load_count  out  ADDR_W+1  words accepted in the current or last session.
REQ-017 err_misalign  out  1  sticky: granted fetch or load with addr[1:0] != 0.
REQ-018 err_range  out  1  sticky: load_addr[31:ADDR_W+2] != 0 on a granted load.
REQ-019 mem_addr  out  ADDR_W  RAM word address.
REQ-020 mem_we  out  1  RAM write enable.
REQ-021 mem_wdata  out  DATA_W  RAM write data.
REQ-022 mem_rdata  in  DATA_W  RAM read data; synchronous, valid one cycle after mem_addr.

Function
REQ-023 FSM states IDLE, FETCH, LOAD; one RAM access per cycle maximum.
REQ-024 IDLE: load_en=1 -> LOAD, no grant that cycle; else fetch_req=1 -> fetch_gnt=1, mem_addr=fetch word index, -> FETCH; else stay IDLE.
REQ-025 FETCH: fetch_rvalid=1, fetch_rdata=mem_rdata; exactly one cycle after each fetch_gnt.
REQ-026 FETCH with load_en=0 and fetch_req=1: grant next fetch same cycle, stay FETCH (throughput 1 word/cycle).
REQ-027 FETCH with load_en=1: return outstanding data, grant nothing, -> LOAD; FETCH otherwise with fetch_req=0 -> IDLE.
REQ-028 load_en takes priority over fetch_req in every state; no fetch is granted while load_en=1.
REQ-029 LOAD with load_en=1: load_gnt=load_req; on grant mem_we=1 unless err_range condition, mem_addr=load_addr[ADDR_W+1:2], mem_wdata=load_wdata.
REQ-030 Out-of-range load: still granted, mem_we=0, err_range set.
REQ-031 load_count cleared to 0 on IDLE/FETCH->LOAD transition; +1 per load_gnt; saturates at 2^ADDR_W; holds value after session ends.
REQ-032 LOAD with load_en=0: load_req ignored, load_gnt=0, -> IDLE.
REQ-033 core_stall = (state==LOAD) OR load_en.
REQ-034 Misaligned addresses are served word-aligned (low two bits dropped) and set err_misalign.
REQ-035 mem_we is never 1 in IDLE or FETCH; fetch_gnt and load_gnt never both 1.
REQ-036 mem_addr/mem_wdata are don't-care when no grant; mem_we=0 then.

Reset
REQ-037 rst_n low: state=IDLE, load_count=0, err_misalign=0, err_range=0 immediately (asynchronous).
REQ-038 While rst_n low: fetch_gnt, fetch_rvalid, load_gnt, mem_we, core_stall all 0 regardless of inputs.
REQ-039 Reset mid-LOAD or mid-FETCH aborts the access; no rvalid or write is produced after deassertion for pre-reset requests.
REQ-040 Error flags clear only on reset.

Verification
REQ-041 RAM preloaded word[i]=i; fetch_req held, fetch_addr 0x0,0x4,0x8 -> fetch_rvalid on 3 consecutive cycles, fetch_rdata 0,1,2, one cycle after each grant.
REQ-042 load_en=1 during FETCH with fetch_req=1 -> pending data returned, no new gnt, core_stall=1, next state LOAD.
REQ-043 LOAD session writes 0xDEAD0000+k to addr 4k, k=0..3, then load_en=0 and fetch 0x8 -> load_count=4, fetch_rdata=0xDEAD0002.
REQ-044 Load to 0x0000_1000 (ADDR_W=10) -> load_gnt=1, mem_we=0, err_range=1; fetch 0x5 -> word 1 returned, err_misalign=1.
REQ-045 1025 granted loads in one session -> load_count stops at 1024.
REQ-046 rst_n pulsed low mid-LOAD with load_req=1 -> mem_we, load_gnt, core_stall drop same cycle; load_count=0, errors 0.
